store_buffer: RTL and testbench
===============================

# store_buffer

Posted-store buffer between the MEM pipeline stage and the data memory (`dmem`). Stores retire into a small FIFO and drain to `dmem` one per cycle when the memory port is free. Loads go to `dmem` directly when no buffered store overlaps their word. Loads that hit a buffered word either stall until it drains or, when the forwarding option is compiled in, are served from the buffer. Downstream it drives the `dmem` port signals `W_en`, `R_en`, `addr`, `RW_type` and `din`, and consumes `dout`.

## Interface
- `DEPTH`, 4: number of store entries; power of two, 2..8.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `st_valid` in 1: store request from MEM.
- `st_ready` out 1: buffer can accept a store (`count < DEPTH`).
- `st_addr` in 32: store byte address.
- `st_data` in 32: store data, right-aligned.
- `st_type` in 3: [1:0] is 00 byte, 01 half, 10 word; [2] is ignored.
- `ld_valid` in 1: load request from MEM.
- `ld_addr` in 32: load byte address.
- `ld_type` in 3: same encoding as `st_type`; [2]=1 means zero-extend.
- `ld_stall` out 1: the load cannot complete this cycle; MEM holds it.
- `ld_data` out 32: load result, valid when `ld_valid && !ld_stall`.
- `mem_W_en`, `mem_R_en` out 1: dmem write and read enables.
- `mem_addr` out 32, `mem_RW_type` out 3, `mem_din` out 32: dmem port.
- `mem_dout` in 32: dmem read data, combinational from `mem_addr`.
- `sb_empty` out 1: `count == 0`; used by fence and halt logic.

## Operation
- FIFO state: `head`, `tail`, `count` and DEPTH entries of {addr, data, type}.
- Enqueue on `st_valid && st_ready`: the entry is written at `tail`, then `tail++` and `count++`.
- Hazard: `ld_valid` and some live entry has `addr[31:2] == ld_addr[31:2]`. Only entries present before this edge are checked, so a store enqueued in the same cycle is younger than the load.
- Port arbitration, one owner per cycle:
  - (1) If `count == DEPTH`, drain has priority.
  - (2) Else if `ld_valid && !hazard`, the load is issued.
  - (3) Else, if `count != 0`, drain.
  - (4) Otherwise the port is idle.
- Drain: `mem_W_en=1`, `mem_addr/mem_din/mem_RW_type` come from the head entry. At the edge, `head++` and `count--`.
- Load issue: `mem_R_en=1`, `mem_addr=ld_addr`, `mem_RW_type=ld_type`, `ld_data=mem_dout`.
- `ld_stall = ld_valid && !(load issued || forwarded)`.
- Enqueue and drain in the same cycle: `count` is unchanged and the pointers advance independently. Pointers wrap modulo DEPTH.
- `st_ready` depends on `count` only, never on the same-cycle drain. A full buffer therefore rejects a store even in a cycle that drains.
- When the port is idle, all mem outputs are 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `count`, `head` and `tail` go to 0.
  - `st_ready=1`, `sb_empty=1`.
  - `mem_W_en=0`, `mem_R_en=0`, `ld_stall=0`, `ld_data=0` while no load is present.
- Reset during a pending drain discards all buffered stores; no write reaches dmem.
- Store latency: a store is accepted at edge N and reaches dmem at edge N+1 at the earliest, if the port is free in cycle N+1.
- A non-hazard load completes in the same cycle (zero added latency).
- A hazard load stalls until every matching entry has drained. It issues in the cycle after the last matching pop.
- Full-buffer stall: a load in a full cycle stalls for exactly one cycle if it has no hazard.

## Configuration
- `SB_WORD_FWD_EN` defined:
  - A hazard load with `ld_type[1:0]==10` is forwarded when the youngest matching entry is a word store at the same word address.
  - In that case `ld_data` is that entry's data, `ld_stall=0`, and the load does not use the port, so the drain may proceed the same cycle.
  - All other hazards stall as without the macro.
- `SB_WORD_FWD_EN` undefined: every hazard stalls and no forwarding logic is built.

## Test plan
- Reset, then sw to 0x100 with data 0xDEADBEEF, port idle -> cycle+1 `mem_W_en=1`, `mem_addr=0x100`, `mem_din=0xDEADBEEF`; cycle+2 `sb_empty=1`.
- Five back-to-back word stores with `DEPTH=4` and a continuous non-hazard load stream -> 5th store sees `st_ready=0`; the drain wins the port in the full cycle; the load shows `ld_stall=1` for exactly that one cycle.
- sb 0xAB to 0x203, then lw 0x200 the next cycle -> `ld_stall=1` until the sb drains; the load then returns the dmem word with byte3 = 0xAB.
- lw 0x300 with buffer entries at 0x304 and 0x2FC only -> no stall; `mem_R_en=1` the same cycle.
- With `SB_WORD_FWD_EN`: sw 0x11111111 then sw 0x22222222 to 0x400, then lw 0x400 -> `ld_data=0x22222222` with `ld_stall=0`. With lh 0x400 -> stall.
- Assert `rst_n` low with 3 entries pending -> no further `mem_W_en`; after release `count=0`, `st_ready=1`.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM and dmem: drains one store per free port cycle, stalls overlapping loads.
// Define SB_WORD_FWD_EN to build word store-to-load forwarding from the youngest matching entry.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_type,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_type,
  output logic        ld_stall,
  output logic [31:0] ld_data,
  output logic        mem_W_en,
  output logic        mem_R_en,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_RW_type,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        sb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [2:0]  type_mem [DEPTH];

  logic             full, enq, drain, load_issue, hazard, fwd;
  logic [DEPTH-1:0] live, match;
  logic [31:0]      fwd_data;

  // An entry is live when its distance from head is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] offset;
      assign offset    = PW'(gi) - head_reg;
      assign live[gi]  = {1'b0, offset} < count_reg;
      assign match[gi] = live[gi] && (addr_mem[gi][31:2] == ld_addr[31:2]);
    end
  endgenerate

  assign full       = (count_reg == FULL_COUNT);
  assign st_ready   = !full;
  assign sb_empty   = (count_reg == '0);
  assign enq        = st_valid && !full;
  assign hazard     = ld_valid && (|match);
  assign load_issue = ld_valid && !hazard && !full;
  assign drain      = !load_issue && (count_reg != '0);

`ifdef SB_WORD_FWD_EN
  logic          fwd_word;
  logic [PW-1:0] scan_idx;

  // Walk oldest to youngest so the last match left standing is the youngest one.
  always_comb begin
    fwd_word = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_reg + PW'(k);
      if ((CW'(k) < count_reg) && (addr_mem[scan_idx][31:2] == ld_addr[31:2])) begin
        fwd_word = (type_mem[scan_idx][1:0] == 2'b10);
        fwd_data = data_mem[scan_idx];
      end
    end
  end

  assign fwd = hazard && (ld_type[1:0] == 2'b10) && fwd_word;
`else
  assign fwd      = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    mem_W_en    = 1'b0;
    mem_R_en    = 1'b0;
    mem_addr    = '0;
    mem_RW_type = '0;
    mem_din     = '0;
    if (drain) begin
      mem_W_en    = 1'b1;
      mem_addr    = addr_mem[head_reg];
      mem_RW_type = type_mem[head_reg];
      mem_din     = data_mem[head_reg];
    end else if (load_issue) begin
      mem_R_en    = 1'b1;
      mem_addr    = ld_addr;
      mem_RW_type = ld_type;
    end
  end

  assign ld_stall = ld_valid && !(load_issue || fwd);
  assign ld_data  = load_issue ? mem_dout : (fwd ? fwd_data : 32'h0);

  assign head_next  = head_reg + PW'(drain);
  assign tail_next  = tail_reg + PW'(enq);
  assign count_next = count_reg + CW'(enq) - CW'(drain);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry payload needs no reset: liveness is governed by the pointers alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_reg] <= st_addr;
      data_mem[tail_reg] <= st_data;
      type_mem[tail_reg] <= st_type;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based reference model and a byte-lane dmem model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready, ld_valid, ld_stall, sb_empty;
  logic [31:0] st_addr, st_data, ld_addr, ld_data;
  logic [2:0]  st_type, ld_type, mem_RW_type;
  logic        mem_W_en, mem_R_en;
  logic [31:0] mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_type(ld_type), .ld_stall(ld_stall), .ld_data(ld_data),
    .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr), .mem_RW_type(mem_RW_type),
    .mem_din(mem_din), .mem_dout(mem_dout), .sb_empty(sb_empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  typ;
  } entry_t;

  entry_t      q[$];
  logic [31:0] dmem    [1024];
  logic [31:0] ref_mem [1024];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] addr,
                                        input logic [31:0] data, input logic [2:0] typ);
    logic [31:0] w;
    w = old;
    case (typ[1:0])
      2'b00:   w[{addr[1:0], 3'b000} +: 8] = data[7:0];
      2'b01:   w[{addr[1], 4'b0000} +: 16] = data[15:0];
      default: w = data;
    endcase
    return w;
  endfunction

  // dmem: combinational read of the aligned word, byte-lane writes at the edge.
  assign mem_dout = dmem[mem_addr[11:2]];
  always @(posedge clk) if (mem_W_en) dmem[mem_addr[11:2]] <= merge(dmem[mem_addr[11:2]], mem_addr, mem_din, mem_RW_type);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] rnd_type();
    logic [2:0] t;
    t[1:0] = 2'($urandom_range(0, 2));
    t[2]   = 1'($urandom_range(0, 1));
    return t;
  endfunction

  function automatic logic [31:0] rnd_addr(input logic [2:0] t);
    logic [31:0] a;
    a = 32'h100 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    if (t[1:0] == 2'b01) a[0] = 1'b0;
    else if (t[1:0] == 2'b10) a[1:0] = 2'b00;
    return a;
  endfunction

  // One cycle: drive at posedge+1, compare at posedge+4, then apply the reference model's edge.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sty,
                      input logic lv, input logic [31:0] la, input logic [2:0] lty,
                      output logic o_stall, output logic o_ready, output logic o_ren, output logic [31:0] o_data);
    int          cnt, yi;
    logic        full, haz, fwd, issue, drain;
    logic [31:0] exp_data;
    st_valid = sv; st_addr = sa; st_data = sd; st_type = sty;
    ld_valid = lv; ld_addr = la; ld_type = lty;
    #3;
    cnt = q.size();
    full = (cnt == DEPTH);
    haz = 1'b0;
    yi = 0;
    for (int i = 0; i < cnt; i++)
      if (lv && q[i].addr[31:2] == la[31:2]) begin haz = 1'b1; yi = i; end
    fwd = 1'b0;
`ifdef SB_WORD_FWD_EN
    fwd = haz && (lty[1:0] == 2'b10) && (q[yi].typ[1:0] == 2'b10);
`endif
    issue = lv && !haz && !full;
    drain = !issue && (cnt != 0);
    check("st_ready", st_ready, !full);
    check("sb_empty", sb_empty, cnt == 0);
    check("ld_stall", ld_stall, lv && !(issue || fwd));
    check("mem_W_en", mem_W_en, drain);
    check("mem_R_en", mem_R_en, issue);
    if (drain) begin
      check("drain_addr", mem_addr, q[0].addr);
      check("drain_din", mem_din, q[0].data);
      check("drain_type", mem_RW_type, q[0].typ);
      $display("drain addr=%h data=%h type=%0d", mem_addr, mem_din, mem_RW_type);
    end else if (issue) begin
      check("rd_addr", mem_addr, la);
      check("rd_type", mem_RW_type, lty);
    end else begin
      check("idle_addr", mem_addr, 32'h0);
    end
    if (issue || fwd) begin
      exp_data = issue ? ref_mem[la[11:2]] : q[yi].data;
      check("ld_data", ld_data, exp_data);
      $display("load addr=%h data=%h fwd=%0d", la, ld_data, fwd);
    end
    o_stall = ld_stall; o_ready = st_ready; o_ren = mem_R_en; o_data = ld_data;
    if (drain) begin
      ref_mem[q[0].addr[11:2]] = merge(ref_mem[q[0].addr[11:2]], q[0].addr, q[0].data, q[0].typ);
      q.delete(0);
    end
    if (sv && !full) q.push_back('{sa, sd, sty});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        s, r, e, sv, lv, hold;
    logic [31:0] d, sa, sd, la;
    logic [2:0]  sty, lty;
    int          n;
    for (int i = 0; i < 1024; i++) begin
      dmem[i]    = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
      ref_mem[i] = dmem[i];
    end
    st_valid = 0; st_addr = 0; st_data = 0; st_type = 0;
    ld_valid = 0; ld_addr = 0; ld_type = 0;
    rst_n = 1'b0;
    #2;
    check("rst_st_ready", st_ready, 1);
    check("rst_sb_empty", sb_empty, 1);
    check("rst_W_en", mem_W_en, 0);
    check("rst_R_en", mem_R_en, 0);
    check("rst_ld_stall", ld_stall, 0);
    check("rst_ld_data", ld_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word store drains on the following idle cycle.
    step(1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 0, s, r, e, d);
    step(0, 0, 0, 0, 0, 0, 0, s, r, e, d);
    step(0, 0, 0, 0, 0, 0, 0, s, r, e, d);

    // Fill with a non-hazard load stream; the full cycle drains and stalls the load once.
    for (int i = 0; i < 4; i++) step(1, 32'h500 + 32'(i * 4), $urandom, 3'b010, 1, 32'h0, 3'b010, s, r, e, d);
    step(1, 32'h510, 32'h55AA55AA, 3'b010, 1, 32'h0, 3'b010, s, r, e, d);
    check("full_st_ready", r, 0);
    check("full_ld_stall", s, 1);
    step(1, 32'h510, 32'h55AA55AA, 3'b010, 1, 32'h0, 3'b010, s, r, e, d);
    check("after_full_stall", s, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, s, r, e, d);

    // Byte store hazard: load waits for the drain, then sees the merged byte.
    step(1, 32'h203, 32'h000000AB, 3'b000, 0, 0, 0, s, r, e, d);
    step(0, 0, 0, 0, 1, 32'h200, 3'b010, s, r, e, d);
    check("sb_hazard_stall", s, 1);
    n = 0;
    while (s && n < 10) begin
      step(0, 0, 0, 0, 1, 32'h200, 3'b010, s, r, e, d);
      n++;
    end
    check("hazard_done", s, 0);
    check("hazard_byte3", d[31:24], 8'hAB);

    // Neighbouring words do not create a hazard.
    step(1, 32'h304, 32'h12345678, 3'b010, 1, 32'h0, 3'b010, s, r, e, d);
    step(1, 32'h2FC, 32'h9ABCDEF0, 3'b010, 1, 32'h0, 3'b010, s, r, e, d);
    step(0, 0, 0, 0, 1, 32'h300, 3'b010, s, r, e, d);
    check("nohaz_stall", s, 0);
    check("nohaz_R_en", e, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, s, r, e, d);

    // Two word stores to one address, then word and half loads of it.
    step(1, 32'h400, 32'h11111111, 3'b010, 1, 32'h0, 3'b010, s, r, e, d);
    step(1, 32'h400, 32'h22222222, 3'b010, 1, 32'h0, 3'b010, s, r, e, d);
    step(0, 0, 0, 0, 1, 32'h400, 3'b010, s, r, e, d);
`ifdef SB_WORD_FWD_EN
    check("fwd_ld_data", d, 32'h22222222);
    check("fwd_ld_stall", s, 0);
`endif
    step(0, 0, 0, 0, 1, 32'h400, 3'b001, s, r, e, d);
`ifdef SB_WORD_FWD_EN
    check("fwd_half_stall", s, 1);
`endif
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, s, r, e, d);

    // Reset with three entries pending discards them.
    for (int i = 0; i < 3; i++) step(1, 32'h600 + 32'(i * 4), $urandom, 3'b010, 1, 32'h0, 3'b010, s, r, e, d);
    st_valid = 0; ld_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("rst_mid_W_en", mem_W_en, 0);
    check("rst_mid_st_ready", st_ready, 1);
    check("rst_mid_sb_empty", sb_empty, 1);
    @(posedge clk); #1;
    check("rst_hold_W_en", mem_W_en, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_no_write", dmem[32'h600 >> 2], ref_mem[32'h600 >> 2]);
    step(0, 0, 0, 0, 0, 0, 0, s, r, e, d);

    // Random traffic; a stalled load is held until it completes.
    hold = 1'b0; lv = 1'b0; la = 0; lty = 0;
    for (int k = 0; k < 600; k++) begin
      sv  = 1'($urandom_range(0, 1));
      sty = rnd_type();
      sa  = rnd_addr(sty);
      sd  = $urandom;
      if (!hold) begin
        lv  = ($urandom_range(0, 99) < 60);
        lty = rnd_type();
        la  = rnd_addr(lty);
      end
      step(sv, sa, sd, sty, lv, la, lty, s, r, e, d);
      hold = lv && s;
    end
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 0, 0, s, r, e, d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
